// File: rtl/gfx_pkg.sv
// Shared definitions for the rectangle command front-end: command layout,
// screen defaults, opcodes and the issue FSM encoding.
package gfx_pkg;

  localparam int CMD_W    = 51;
  localparam int OP_BIT   = 50;
  localparam int TLX_LSB  = 40;
  localparam int TLX_W    = 10;
  localparam int TLY_LSB  = 31;
  localparam int TLY_W    = 9;
  localparam int BRX_LSB  = 21;
  localparam int BRX_W    = 10;
  localparam int BRY_LSB  = 12;
  localparam int BRY_W    = 9;
  localparam int ARG_LSB  = 0;
  localparam int ARG_W    = 12;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_DRAW = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } issue_state_t;

  // Field order mirrors the 51-bit command word, MSB first.
  typedef struct packed {
    logic             opcode;
    logic [TLX_W-1:0] tl_x;
    logic [TLY_W-1:0] tl_y;
    logic [BRX_W-1:0] br_x;
    logic [BRY_W-1:0] br_y;
    logic [ARG_W-1:0] arg;
  } gfx_cmd_t;

  function automatic logic cmd_in_bounds(input gfx_cmd_t c, input int w, input int h);
    return (c.tl_x <= c.br_x) && (c.tl_y <= c.br_y) &&
           (int'(c.br_x) < w) && (int'(c.br_y) < h);
  endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. Head word is visible combinationally for a same-cycle pop.
module gfx_cmd_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] din,
  input  logic             pop,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/gfx_cmd_scheduler.sv
// Two-requester rectangle command front-end: round-robin accept, bounds
// validation, FIFO buffering and en/finish issue to the graphics processor.
module gfx_cmd_scheduler
  import gfx_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [CMD_W-1:0] s0_cmd,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [CMD_W-1:0] s1_cmd,
  input  logic             hold,
  output logic             gp_en,
  output logic             gp_opcode,
  output logic [9:0]       gp_tl_x,
  output logic [8:0]       gp_tl_y,
  output logic [9:0]       gp_br_x,
  output logic [8:0]       gp_br_y,
  output logic [11:0]      gp_arg,
  input  logic             gp_finish,
  output logic             busy,
  output logic             err_drop,
  output logic [7:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);

  issue_state_t r_state;
  gfx_cmd_t     r_gp_cmd;
  logic         r_gp_en;
  logic         r_busy;
  logic         r_last_grant;
  logic         r_err_drop;
  logic [7:0]   r_drop_count;

  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  gfx_cmd_t     w_cmd;
  logic         w_cmd_ok;
  logic         w_push;
  logic         w_drop;
  logic         w_launch;
  logic         w_run_next;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic [AW:0]  w_count_next;
  logic [CMD_W-1:0] w_head;

  // r_last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
  assign w_grant0 = s0_valid && (!s1_valid || r_last_grant);
  assign w_grant1 = s1_valid && (!s0_valid || !r_last_grant);
  assign s0_ready = !w_full && w_grant0;
  assign s1_ready = !w_full && w_grant1;

  assign w_accept = s0_ready || s1_ready;
  assign w_cmd    = gfx_cmd_t'(s1_ready ? s1_cmd : s0_cmd);
  assign w_cmd_ok = cmd_in_bounds(w_cmd, WIDTH, HEIGHT);
  assign w_push   = w_accept && w_cmd_ok;
  assign w_drop   = w_accept && !w_cmd_ok;

  assign w_launch     = ((r_state == ST_IDLE) || (r_state == ST_GAP)) && !w_empty && !hold;
  assign w_run_next   = w_launch || ((r_state == ST_RUN) && !gp_finish);
  assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_launch);

  gfx_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_cmd),
    .pop   (w_launch),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gp_en  <= 1'b0;
      r_gp_cmd <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= (w_count_next != '0) || w_run_next;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_launch) begin
            r_gp_cmd <= gfx_cmd_t'(w_head);
            r_gp_en  <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (gp_finish) begin
            r_gp_en <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        default: begin
          r_gp_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_err_drop   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_accept) r_last_grant <= s1_ready;
      if (w_drop) begin
        r_err_drop <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign gp_en      = r_gp_en;
  assign gp_opcode  = r_gp_cmd.opcode;
  assign gp_tl_x    = r_gp_cmd.tl_x;
  assign gp_tl_y    = r_gp_cmd.tl_y;
  assign gp_br_x    = r_gp_cmd.br_x;
  assign gp_br_y    = r_gp_cmd.br_y;
  assign gp_arg     = r_gp_cmd.arg;
  assign busy       = r_busy;
  assign err_drop   = r_err_drop;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Directed bench for gfx_cmd_scheduler with a finish-after-N-cycles processor stub.
module tb_gfx_cmd_scheduler;
  import gfx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [50:0] s0_cmd = '0, s1_cmd = '0;
  logic        hold = 1'b0;
  logic        gp_en, gp_opcode, gp_finish = 1'b0;
  logic [9:0]  gp_tl_x, gp_br_x;
  logic [8:0]  gp_tl_y, gp_br_y;
  logic [11:0] gp_arg;
  logic        busy, err_drop;
  logic [7:0]  drop_count;
  logic [50:0] obs;

  int checks = 0;
  int errors = 0;
  int stub_delay = 0;
  int cyc = 0;
  logic [50:0] issued_q[$];
  int rise_cyc[$];
  int fall_cyc[$];

  always #5 clk = ~clk;

  gfx_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_cmd(s0_cmd),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_cmd(s1_cmd),
    .hold(hold), .gp_en(gp_en), .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
    .gp_arg(gp_arg), .gp_finish(gp_finish), .busy(busy),
    .err_drop(err_drop), .drop_count(drop_count)
  );

  assign obs = {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg};

  function automatic logic [50:0] mk(logic op, int tlx, int tly, int brx, int bry, int arg);
    return {op, 10'(tlx), 9'(tly), 10'(brx), 9'(bry), 12'(arg)};
  endfunction

  // Processor stub: raise finish once gp_en has been high for stub_delay cycles (0 = never).
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (gp_en && stub_delay != 0) begin
        cnt++;
        if (cnt >= stub_delay) gp_finish = 1'b1;
      end else begin
        cnt = 0;
        gp_finish = 1'b0;
      end
    end
  end

  // Monitor: log every launch and every fall of gp_en with its cycle number.
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (gp_en === 1'b1 && prev_en !== 1'b1) begin
        issued_q.push_back(obs);
        rise_cyc.push_back(cyc);
      end
      if (gp_en !== 1'b1 && prev_en === 1'b1) fall_cyc.push_back(cyc);
      prev_en = gp_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; hold = 1'b0; stub_delay = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    issued_q.delete(); rise_cyc.delete(); fall_cyc.delete();
  endtask

  task automatic send(int port, logic [50:0] cmd, int bound, output int ok);
    ok = 0;
    if (port == 0) begin s0_cmd = cmd; s0_valid = 1'b1; end
    else begin s1_cmd = cmd; s1_valid = 1'b1; end
    for (int i = 0; i < bound && ok == 0; i++) begin
      @(negedge clk);
      if ((port == 0 && s0_ready === 1'b1) || (port == 1 && s1_ready === 1'b1)) ok = 1;
      @(posedge clk); #1;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic wait_issues(int n, int bound);
    for (int i = 0; i < bound; i++) begin
      if (issued_q.size() >= n && fall_cyc.size() >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s0_valid = 1'b1; s1_valid = 1'b0; s0_cmd = mk(OP_FILL, 1, 1, 2, 2, 3);
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (gp_en !== 1'b0) begin errors++; $display("FAIL reset_gp_en got %b want 0", gp_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_drop !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %b/%0d want 0/0", err_drop, drop_count); end
    checks++; if (obs !== 51'd0) begin errors++; $display("FAIL reset_args got %h want 0", obs); end
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 10", s0_ready, s1_ready); end
    @(posedge clk); #1;
    s0_valid = 1'b0; rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_fill();
    logic [50:0] e;
    int high, stable;
    do_reset();
    stub_delay = 8;
    e = mk(OP_FILL, 0, 0, 3, 1, 12'hF00);
    s0_cmd = e; s0_valid = 1'b1;
    @(negedge clk);
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b want 1", s0_ready); end
    @(posedge clk); #1; s0_valid = 1'b0;
    checks++; if (gp_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fill_t1 got en=%b busy=%b want en=0 busy=1", gp_en, busy); end
    @(posedge clk); #1;
    checks++; if (gp_en !== 1'b1 || obs !== e) begin errors++; $display("FAIL fill_launch got en=%b args=%h want en=1 args=%h", gp_en, obs, e); end
    high = 1; stable = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (gp_en !== 1'b1) break;
      high++;
      if (obs !== e) stable = 0;
    end
    checks++; if (high != 8) begin errors++; $display("FAIL fill_en_width got %0d want 8", high); end
    checks++; if (stable != 1) begin errors++; $display("FAIL fill_args_stable got %0d want 1", stable); end
    @(posedge clk); #1;
    checks++; if (gp_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill_done got en=%b busy=%b want 0/0", gp_en, busy); end
    checks++; if (issued_q.size() != 1) begin errors++; $display("FAIL fill_issue_count got %0d want 1", issued_q.size()); end
    $display("test_single_fill done");
  endtask

  task automatic test_tie();
    logic [50:0] a[4], b[4], e[4];
    do_reset();
    hold = 1'b1; stub_delay = 2;
    for (int k = 0; k < 4; k++) begin
      a[k] = mk(OP_FILL, k, k, 10 + k, 10 + k, 256 + k);
      b[k] = mk(OP_DRAW, 20 + k, k, 30 + k, 5 + k, 512 + k);
    end
    e[0] = a[0]; e[1] = b[1]; e[2] = a[2]; e[3] = b[3];
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s0_cmd = a[k]; s1_cmd = b[k];
      @(negedge clk);
      checks++; if (s0_ready !== 1'((k % 2) == 0) || s1_ready !== 1'((k % 2) == 1)) begin errors++; $display("FAIL tie_grant%0d got %b%b want %b%b", k, s0_ready, s1_ready, 1'((k % 2) == 0), 1'((k % 2) == 1)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL tie_full_ready got %b%b want 00", s0_ready, s1_ready); end
    @(posedge clk); #1; s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (gp_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tie_hold got en=%b busy=%b want 0/1", gp_en, busy); end
    hold = 1'b0;
    wait_issues(4, 100);
    checks++; if (issued_q.size() != 4) begin errors++; $display("FAIL tie_issue_count got %0d want 4", issued_q.size()); end
    for (int k = 0; k < 4 && k < issued_q.size(); k++) begin
      checks++; if (issued_q[k] !== e[k]) begin errors++; $display("FAIL tie_order%0d got %h want %h", k, issued_q[k], e[k]); end
    end
    for (int k = 0; k < 3 && k + 1 < rise_cyc.size() && k < fall_cyc.size(); k++) begin
      checks++; if (rise_cyc[k+1] - fall_cyc[k] != 1) begin errors++; $display("FAIL tie_gap%0d got %0d want 1", k, rise_cyc[k+1] - fall_cyc[k]); end
    end
    $display("test_tie done");
  endtask

  task automatic test_backpressure();
    logic [50:0] c[6];
    int ok, blocked, seen;
    do_reset();
    stub_delay = 0;
    for (int k = 0; k < 6; k++) c[k] = mk(OP_DRAW, 2 * k, k, 2 * k + 5, k + 3, 768 + k);
    for (int k = 0; k < 5; k++) begin
      send(1, c[k], 10, ok);
      checks++; if (ok != 1) begin errors++; $display("FAIL bp_accept%0d got %0d want 1", k, ok); end
    end
    checks++; if (gp_en !== 1'b1 || obs !== c[0]) begin errors++; $display("FAIL bp_first got en=%b args=%h want en=1 args=%h", gp_en, obs, c[0]); end
    s1_cmd = c[5]; s1_valid = 1'b1;
    blocked = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s1_ready !== 1'b0) blocked = 0;
    end
    checks++; if (blocked != 1) begin errors++; $display("FAIL bp_sixth_blocked got %0d want 1", blocked); end
    stub_delay = 1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (s1_ready === 1'b1) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL bp_sixth_accept got %0d want 1", seen); end
    @(posedge clk); #1; s1_valid = 1'b0;
    wait_issues(6, 200);
    checks++; if (issued_q.size() != 6) begin errors++; $display("FAIL bp_issue_count got %0d want 6", issued_q.size()); end
    for (int k = 0; k < 6 && k < issued_q.size(); k++) begin
      checks++; if (issued_q[k] !== c[k]) begin errors++; $display("FAIL bp_order%0d got %h want %h", k, issued_q[k], c[k]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_validation();
    logic [50:0] v0, v1, v2, v3, v4;
    int ok;
    do_reset();
    stub_delay = 3;
    v0 = mk(OP_FILL, 0, 0, 640, 10, 1);
    v1 = mk(OP_FILL, 0, 5, 10, 4, 2);
    v2 = mk(OP_DRAW, 0, 0, 639, 479, 12'hABC);
    v3 = mk(OP_FILL, 11, 0, 10, 0, 3);
    v4 = mk(OP_FILL, 0, 0, 10, 480, 4);
    send(0, v0, 5, ok);
    checks++; if (ok != 1) begin errors++; $display("FAIL val_drop_handshake got %0d want 1", ok); end
    checks++; if (err_drop !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL val_first_drop got %b/%0d want 1/1", err_drop, drop_count); end
    send(0, v1, 5, ok);
    send(0, v2, 5, ok);
    checks++; if (err_drop !== 1'b1 || drop_count !== 8'd2) begin errors++; $display("FAIL val_drops got %b/%0d want 1/2", err_drop, drop_count); end
    wait_issues(1, 50);
    repeat (8) @(posedge clk); #1;
    checks++; if (issued_q.size() != 1) begin errors++; $display("FAIL val_issue_count got %0d want 1", issued_q.size()); end
    if (issued_q.size() > 0) begin
      checks++; if (issued_q[0] !== v2) begin errors++; $display("FAIL val_issue_args got %h want %h", issued_q[0], v2); end
    end
    send(1, v3, 5, ok);
    send(1, v4, 5, ok);
    repeat (3) @(posedge clk); #1;
    checks++; if (drop_count !== 8'd4 || issued_q.size() != 1) begin errors++; $display("FAIL val_more_drops got %0d/%0d want 4/1", drop_count, issued_q.size()); end
    $display("test_validation done");
  endtask

  task automatic test_hold();
    logic [50:0] h0, h1;
    int ok, quiet;
    do_reset();
    hold = 1'b1; stub_delay = 2;
    h0 = mk(OP_FILL, 100, 50, 200, 60, 12'h0F0);
    h1 = mk(OP_DRAW, 5, 6, 7, 8, 12'h123);
    send(0, h0, 5, ok);
    send(0, h1, 5, ok);
    quiet = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gp_en !== 1'b0) quiet = 0;
    end
    checks++; if (quiet != 1 || busy !== 1'b1) begin errors++; $display("FAIL hold_quiet got quiet=%0d busy=%b want 1/1", quiet, busy); end
    @(posedge clk); #1; hold = 1'b0;
    wait_issues(2, 50);
    checks++; if (issued_q.size() != 2) begin errors++; $display("FAIL hold_issue_count got %0d want 2", issued_q.size()); end
    if (issued_q.size() == 2) begin
      checks++; if (issued_q[0] !== h0 || issued_q[1] !== h1) begin errors++; $display("FAIL hold_order got %h %h want %h %h", issued_q[0], issued_q[1], h0, h1); end
    end
    if (rise_cyc.size() == 2 && fall_cyc.size() >= 1) begin
      checks++; if (rise_cyc[1] - fall_cyc[0] != 1) begin errors++; $display("FAIL hold_gap got %0d want 1", rise_cyc[1] - fall_cyc[0]); end
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_mid_run();
    int ok, n;
    do_reset();
    stub_delay = 0;
    for (int k = 0; k < 3; k++) send(0, mk(OP_FILL, k, k, k + 1, k + 1, k), 5, ok);
    checks++; if (gp_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmr_running got en=%b busy=%b want 1/1", gp_en, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (gp_en !== 1'b0 || busy !== 1'b0 || obs !== 51'd0) begin errors++; $display("FAIL rmr_reset got en=%b busy=%b args=%h want 0/0/0", gp_en, busy, obs); end
    rst = 1'b0;
    n = issued_q.size();
    stub_delay = 1;
    repeat (10) @(posedge clk); #1;
    checks++; if (gp_en !== 1'b0 || busy !== 1'b0 || issued_q.size() != n) begin errors++; $display("FAIL rmr_after got en=%b busy=%b issues=%0d want 0/0/%0d", gp_en, busy, issued_q.size(), n); end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_saturation();
    do_reset();
    s1_cmd = mk(OP_FILL, 5, 0, 4, 0, 0);
    s1_valid = 1'b1;
    repeat (100) @(posedge clk); #1;
    checks++; if (drop_count !== 8'd100) begin errors++; $display("FAIL sat_mid got %0d want 100", drop_count); end
    repeat (157) @(posedge clk); #1;
    s1_valid = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd255 || err_drop !== 1'b1) begin errors++; $display("FAIL sat_end got %0d/%b want 255/1", drop_count, err_drop); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_tie();
    test_backpressure();
    test_validation();
    test_hold();
    test_reset_mid_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
